// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the 16-bit accumulator datapath.
// Splits each instruction into FETCH/DECODE/EXEC/MEM/WB steps and issues one-cycle
// enable strobes to PC, IR/AR, ACC, flags and register file. Data memory is accessed
// through a req/ack handshake guarded by a timeout. Also provides single-step control
// and busy-cycle / retired-instruction counters.
module multicycle_sequencer #(
   parameter logic [5:0]  OP_LOAD     = 6'b000100,
   parameter logic [5:0]  OP_STORE    = 6'b000101,
   parameter logic [5:0]  OP_HALT     = 6'b111111,
   parameter logic [3:0]  BR_PREFIX   = 4'b0010,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        step_mode,
   input  logic [5:0]  opcode,
   input  logic        imem_ready,
   input  logic        mem_ack,
   output logic        ir_load,
   output logic        pc_en,
   output logic        pc_sel,
   output logic        acc_en,
   output logic        flags_en,
   output logic        rf_we,
   output logic        mem_req,
   output logic        mem_we,
   output logic [2:0]  state,
   output logic        busy,
   output logic        halted,
   output logic        err,
   output logic [15:0] cycle_count,
   output logic [15:0] instr_count
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StMem    = 3'd4,
      StWb     = 3'd5,
      StHalt   = 3'd6,
      StErr    = 3'd7
   } state_e;

   // Timeout limit narrowed once so the MEM compare stays width-matched.
   localparam logic [7:0] TimeoutLimit = 8'(MEM_TIMEOUT);

   state_e      state_q, state_d;
   logic [5:0]  op_q, op_d;
   logic [7:0]  tmo_q, tmo_d;
   logic [15:0] cycle_count_q, cycle_count_d;
   logic [15:0] instr_count_q, instr_count_d;

   logic        is_branch;
   logic        is_load;
   logic        is_store;
   logic        is_mem_op;
   logic        retire;
   logic        busy_int;
   logic [7:0]  tmo_inc;

   // Classify the latched opcode; branch prefix takes priority over exact matches.
   always_comb begin
      is_branch = (op_q[5:2] == BR_PREFIX);
      is_load   = !is_branch && (op_q == OP_LOAD);
      is_store  = !is_branch && (op_q == OP_STORE);
      is_mem_op = is_load || is_store;
   end

   // Busy flag and retire point, both derived from the current state only.
   always_comb begin
      busy_int = !((state_q == StIdle) || (state_q == StHalt) || (state_q == StErr));
      retire   = ((state_q == StExec) && is_branch) || (state_q == StWb);
   end

   // Next-state logic, opcode latch and MEM timeout counter.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      tmo_d   = tmo_q;
      tmo_inc = tmo_q + 8'd1;
      unique case (state_q)
         StIdle: begin
            if (run) begin
               state_d = StFetch;
            end
         end
         StFetch: begin
            if (imem_ready) begin
               state_d = StDecode;
            end
         end
         StDecode: begin
            op_d = opcode;
            if (opcode == OP_HALT) begin
               state_d = StHalt;
            end else begin
               state_d = StExec;
            end
         end
         StExec: begin
            if (is_branch) begin
               state_d = step_mode ? StIdle : StFetch;
            end else if (is_mem_op) begin
               tmo_d   = 8'd0;
               state_d = StMem;
            end else begin
               state_d = StWb;
            end
         end
         StMem: begin
            // An ack arriving on the limit cycle still completes the transfer.
            if (mem_ack) begin
               state_d = StWb;
            end else begin
               tmo_d = tmo_inc;
               if (tmo_inc == TimeoutLimit) begin
                  state_d = StErr;
               end
            end
         end
         StWb: begin
            state_d = step_mode ? StIdle : StFetch;
         end
         StHalt: begin
            state_d = StHalt;
         end
         StErr: begin
            state_d = StErr;
         end
      endcase
   end

   // Performance counters: busy cycles saturate, retired instructions wrap.
   always_comb begin
      cycle_count_d = cycle_count_q;
      instr_count_d = instr_count_q;
      if (busy_int && (cycle_count_q != 16'hFFFF)) begin
         cycle_count_d = cycle_count_q + 16'd1;
      end
      if (retire) begin
         instr_count_d = instr_count_q + 16'd1;
      end
   end

   // Moore-style strobe decode; only ir_load also looks at imem_ready.
   always_comb begin
      ir_load  = 1'b0;
      pc_en    = 1'b0;
      pc_sel   = 1'b0;
      acc_en   = 1'b0;
      flags_en = 1'b0;
      rf_we    = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      halted   = 1'b0;
      err      = 1'b0;
      unique case (state_q)
         StIdle: begin
         end
         StFetch: begin
            ir_load = imem_ready;
         end
         StDecode: begin
         end
         StExec: begin
            if (is_branch) begin
               pc_en  = 1'b1;
               pc_sel = 1'b1;
            end else if (!is_mem_op) begin
               acc_en   = 1'b1;
               flags_en = 1'b1;
            end
         end
         StMem: begin
            mem_req = 1'b1;
            mem_we  = is_store;
         end
         StWb: begin
            pc_en = 1'b1;
            rf_we = !is_store;
         end
         StHalt: begin
            halted = 1'b1;
         end
         StErr: begin
            err = 1'b1;
         end
      endcase
   end

   // State, opcode latch, timeout and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         op_q          <= 6'd0;
         tmo_q         <= 8'd0;
         cycle_count_q <= 16'd0;
         instr_count_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         tmo_q         <= tmo_d;
         cycle_count_q <= cycle_count_d;
         instr_count_q <= instr_count_d;
      end
   end

   assign state       = state_q;
   assign busy        = busy_int;
   assign cycle_count = cycle_count_q;
   assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer.
module tb_multicycle_sequencer;

   localparam logic [5:0] OpLoad  = 6'b000100;
   localparam logic [5:0] OpStore = 6'b000101;
   localparam logic [5:0] OpHalt  = 6'b111111;
   localparam logic [5:0] OpAlu   = 6'b000001;
   localparam logic [5:0] OpBr    = 6'b001011;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic        step_mode = 1'b0;
   logic [5:0]  opcode = 6'd0;
   logic        imem_ready = 1'b0;
   logic        mem_ack = 1'b0;
   logic        ir_load, pc_en, pc_sel, acc_en, flags_en, rf_we, mem_req, mem_we;
   logic [2:0]  state;
   logic        busy, halted, err;
   logic [15:0] cycle_count, instr_count;

   int n_cmp = 0;
   int n_fail = 0;

   multicycle_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .step_mode   (step_mode),
      .opcode      (opcode),
      .imem_ready  (imem_ready),
      .mem_ack     (mem_ack),
      .ir_load     (ir_load),
      .pc_en       (pc_en),
      .pc_sel      (pc_sel),
      .acc_en      (acc_en),
      .flags_en    (flags_en),
      .rf_we       (rf_we),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .state       (state),
      .busy        (busy),
      .halted      (halted),
      .err         (err),
      .cycle_count (cycle_count),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   // All strobes and status bits packed for compact comparisons.
   function automatic logic [9:0] strobes();
      return {ir_load, pc_en, pc_sel, acc_en, flags_en, rf_we, mem_req, mem_we, halted, err};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      run = 1'b0;
      mem_ack = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #120;
      rst = 1'b0;
      repeat (10) @(negedge clk);
      n_cmp++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (strobes() !== 10'd0) begin n_fail++; $display("FAIL reset_strobes: got %b want 0", strobes()); end
      n_cmp++; if (cycle_count !== 16'd0) begin n_fail++; $display("FAIL reset_cycles: got %0d want 0", cycle_count); end
      n_cmp++; if (instr_count !== 16'd0) begin n_fail++; $display("FAIL reset_instrs: got %0d want 0", instr_count); end
   endtask

   task automatic test_alu();
      step_mode = 1'b0;
      @(negedge clk);
      run = 1'b1; opcode = OpAlu; imem_ready = 1'b1;
      @(negedge clk);
      run = 1'b0;
      n_cmp++; if ({state, ir_load} !== {3'd1, 1'b1}) begin n_fail++; $display("FAIL alu_fetch: got st=%0d ir=%b want st=1 ir=1", state, ir_load); end
      @(negedge clk);
      n_cmp++; if (state !== 3'd2) begin n_fail++; $display("FAIL alu_decode: got %0d want 2", state); end
      @(negedge clk);
      n_cmp++; if (strobes() !== 10'b0001100000 || state !== 3'd3) begin n_fail++; $display("FAIL alu_exec: got st=%0d strb=%b want st=3 strb=0001100000", state, strobes()); end
      @(negedge clk);
      n_cmp++; if (strobes() !== 10'b0100010000 || state !== 3'd5) begin n_fail++; $display("FAIL alu_wb: got st=%0d strb=%b want st=5 strb=0100010000", state, strobes()); end
      @(negedge clk);
      n_cmp++; if (state !== 3'd1) begin n_fail++; $display("FAIL alu_refetch: got %0d want 1", state); end
      n_cmp++; if (instr_count !== 16'd1) begin n_fail++; $display("FAIL alu_instrs: got %0d want 1", instr_count); end
      n_cmp++; if (cycle_count !== 16'd4) begin n_fail++; $display("FAIL alu_cycles: got %0d want 4", cycle_count); end
      // Second ALU instruction in step mode returns to IDLE after WB.
      step_mode = 1'b1;
      repeat (4) @(negedge clk);
      n_cmp++; if (state !== 3'd0) begin n_fail++; $display("FAIL alu_step_idle: got %0d want 0", state); end
      n_cmp++; if ({instr_count, cycle_count} !== {16'd2, 16'd8}) begin n_fail++; $display("FAIL alu_step_counts: got i=%0d c=%0d want i=2 c=8", instr_count, cycle_count); end
   endtask

   task automatic test_load();
      @(negedge clk);
      run = 1'b1; opcode = OpLoad;
      @(negedge clk);
      run = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (state !== 3'd3 || strobes() !== 10'd0) begin n_fail++; $display("FAIL load_exec: got st=%0d strb=%b want st=3 strb=0", state, strobes()); end
      opcode = OpAlu;  // must be ignored: op_q holds until the next DECODE
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         n_cmp++; if ({state, mem_req, mem_we} !== {3'd4, 1'b1, 1'b0}) begin n_fail++; $display("FAIL load_mem%0d: got st=%0d req=%b we=%b want st=4 req=1 we=0", k, state, mem_req, mem_we); end
         if (k == 3) mem_ack = 1'b1;
      end
      @(negedge clk);
      mem_ack = 1'b0;
      n_cmp++; if (strobes() !== 10'b0100010000 || state !== 3'd5) begin n_fail++; $display("FAIL load_wb: got st=%0d strb=%b want st=5 strb=0100010000", state, strobes()); end
      @(negedge clk);
      n_cmp++; if ({state, instr_count, cycle_count} !== {3'd0, 16'd3, 16'd15}) begin n_fail++; $display("FAIL load_end: got st=%0d i=%0d c=%0d want st=0 i=3 c=15", state, instr_count, cycle_count); end
   endtask

   task automatic test_store();
      @(negedge clk);
      run = 1'b1; opcode = OpStore;
      @(negedge clk);
      run = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if ({state, mem_req, mem_we} !== {3'd4, 1'b1, 1'b1}) begin n_fail++; $display("FAIL store_mem: got st=%0d req=%b we=%b want st=4 req=1 we=1", state, mem_req, mem_we); end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      n_cmp++; if ({state, rf_we, pc_en, pc_sel} !== {3'd5, 1'b0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL store_wb: got st=%0d rf=%b pc=%b sel=%b want st=5 rf=0 pc=1 sel=0", state, rf_we, pc_en, pc_sel); end
      @(negedge clk);
      n_cmp++; if ({state, instr_count, cycle_count} !== {3'd0, 16'd4, 16'd20}) begin n_fail++; $display("FAIL store_end: got st=%0d i=%0d c=%0d want st=0 i=4 c=20", state, instr_count, cycle_count); end
   endtask

   task automatic test_timeout();
      int bad = 0;
      @(negedge clk);
      run = 1'b1; opcode = OpStore;
      @(negedge clk);
      run = 1'b0;
      repeat (2) @(negedge clk);
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (state !== 3'd4 || mem_req !== 1'b1) bad++;
      end
      n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL timeout_mem_span: got %0d bad MEM cycles want 0", bad); end
      @(negedge clk);
      n_cmp++; if ({state, err, busy, mem_req} !== {3'd7, 1'b1, 1'b0, 1'b0}) begin n_fail++; $display("FAIL timeout_err: got st=%0d err=%b busy=%b req=%b want st=7 err=1 busy=0 req=0", state, err, busy, mem_req); end
      run = 1'b1;
      repeat (3) @(negedge clk);
      run = 1'b0;
      n_cmp++; if ({state, err} !== {3'd7, 1'b1}) begin n_fail++; $display("FAIL timeout_sticky: got st=%0d err=%b want st=7 err=1", state, err); end
      n_cmp++; if ({instr_count, cycle_count} !== {16'd4, 16'd38}) begin n_fail++; $display("FAIL timeout_counts: got i=%0d c=%0d want i=4 c=38", instr_count, cycle_count); end
      do_reset();
      n_cmp++; if ({state, err, cycle_count} !== {3'd0, 1'b0, 16'd0}) begin n_fail++; $display("FAIL timeout_rst: got st=%0d err=%b c=%0d want st=0 err=0 c=0", state, err, cycle_count); end
      // Ack on the limit cycle wins over the timeout.
      run = 1'b1; opcode = OpStore;
      @(negedge clk);
      run = 1'b0;
      repeat (2) @(negedge clk);
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (k == 15) mem_ack = 1'b1;
      end
      @(negedge clk);
      mem_ack = 1'b0;
      n_cmp++; if ({state, err} !== {3'd5, 1'b0}) begin n_fail++; $display("FAIL timeout_ack_late: got st=%0d err=%b want st=5 err=0", state, err); end
      @(negedge clk);
      n_cmp++; if ({state, instr_count, cycle_count} !== {3'd0, 16'd1, 16'd19}) begin n_fail++; $display("FAIL timeout_ack_end: got st=%0d i=%0d c=%0d want st=0 i=1 c=19", state, instr_count, cycle_count); end
   endtask

   task automatic test_branch_halt();
      do_reset();
      step_mode = 1'b1;
      run = 1'b1; opcode = OpBr;
      @(negedge clk);
      run = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if ({state, strobes()} !== {3'd3, 10'b0110000000}) begin n_fail++; $display("FAIL branch_exec: got st=%0d strb=%b want st=3 strb=0110000000", state, strobes()); end
      @(negedge clk);
      n_cmp++; if ({state, instr_count, cycle_count} !== {3'd0, 16'd1, 16'd3}) begin n_fail++; $display("FAIL branch_end: got st=%0d i=%0d c=%0d want st=0 i=1 c=3", state, instr_count, cycle_count); end
      run = 1'b1; opcode = OpHalt;
      repeat (3) @(negedge clk);
      n_cmp++; if ({state, halted, busy} !== {3'd6, 1'b1, 1'b0}) begin n_fail++; $display("FAIL halt_enter: got st=%0d halted=%b busy=%b want st=6 halted=1 busy=0", state, halted, busy); end
      repeat (3) @(negedge clk);
      run = 1'b0;
      n_cmp++; if ({state, strobes()} !== {3'd6, 10'b0000000010}) begin n_fail++; $display("FAIL halt_hold: got st=%0d strb=%b want st=6 strb=0000000010", state, strobes()); end
      n_cmp++; if ({instr_count, cycle_count} !== {16'd1, 16'd5}) begin n_fail++; $display("FAIL halt_counts: got i=%0d c=%0d want i=1 c=5", instr_count, cycle_count); end
   endtask

   task automatic test_async_reset_mem();
      do_reset();
      run = 1'b1; opcode = OpLoad;
      @(negedge clk);
      run = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL arst_pre_req: got %b want 1", mem_req); end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_cmp++; if ({state, mem_req, strobes()} !== {3'd0, 1'b0, 10'd0}) begin n_fail++; $display("FAIL arst_mid_mem: got st=%0d req=%b strb=%b want st=0 req=0 strb=0", state, mem_req, strobes()); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_timeout();
      test_branch_halt();
      test_async_reset_mem();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
